// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller.
//   sar_state_e    : controller states
//   CNT_W          : width of the sample-phase down-counter (covers 1..15 cycles)
//   sar_params_ok  : legality of the NBITS / SAMPLE_CYCLES parameter pair,
//                    evaluated at elaboration by the top level
package sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_CONV   = 2'd2,
      ST_DONE   = 2'd3
   } sar_state_e;

   localparam int CNT_W = $clog2(16);

   function automatic bit sar_params_ok(input int nbits, input int sample_cycles);
      return (nbits >= 2) && (nbits <= 12) &&
             (sample_cycles >= 1) && (sample_cycles <= 15);
   endfunction

endpackage

// File: rtl/sar_trial_shifter.sv
// One-hot trial shift register with per-bit result capture.
//   clk      : conversion clock
//   rst_n    : synchronous active-low reset, clears trial and res
//   clear    : clear trial and res (end of conversion)
//   load     : start a conversion: trial = MSB one-hot, res = 0
//   shift    : capture comp_in into the bit under trial, then move trial right
//   comp_in  : comparator decision for the bit under trial
//   trial    : one-hot bit under trial (0 outside a conversion)
//   res      : result bits decided so far
//   res_nxt  : res with the current decision merged in; only meaningful while
//              shift is high, used to register the final word without a wait cycle
//   last     : the LSB is under trial
module sar_trial_shifter
   import sar_pkg::*;
#(
   parameter int NBITS = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             shift,
   input  logic             comp_in,
   output logic [NBITS-1:0] trial,
   output logic [NBITS-1:0] res,
   output logic [NBITS-1:0] res_nxt,
   output logic             last
);

   localparam logic [NBITS-1:0] MSB_ONEHOT = {1'b1, {(NBITS-1){1'b0}}};

   assign res_nxt = (res & ~trial) | (trial & {NBITS{comp_in}});
   assign last    = trial[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trial <= '0;
         res   <= '0;
      end else if (clear) begin
         trial <= '0;
         res   <= '0;
      end else if (load) begin
         trial <= MSB_ONEHOT;
         res   <= '0;
      end else if (shift) begin
         trial <= trial >> 1;
         res   <= res_nxt;
      end
   end

endmodule

// File: rtl/sar_ctrl_param.sv
// Parametrised successive-approximation register controller.
//   clk      : conversion clock
//   rst_n    : synchronous active-low reset
//   start    : request one conversion (honoured only in IDLE)
//   cont     : continuous mode, examined in DONE
//   comp_in  : comparator decision, 1 keeps the bit under trial
//   comp_en  : comparator enable, high through CONV
//   sample   : sample-phase strobe
//   sw / swb : DAC switch controls (MSB first) and their complement
//   busy     : conversion in progress (SAMPLE, CONV, DONE)
//   data     : last completed result, held until the next DONE
//   valid    : one-cycle pulse coinciding with a data update
//
// state  | meaning
// IDLE   | waiting for start; strobes low, res = 0
// SAMPLE | input tracking for SAMPLE_CYCLES cycles, sw all ones
// CONV   | one bit decided per cycle, MSB first
// DONE   | result registered, valid high; loop to SAMPLE when cont
module sar_ctrl_param
   import sar_pkg::*;
#(
   parameter int NBITS         = 6,
   parameter int SAMPLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             comp_in,
   output logic             comp_en,
   output logic             sample,
   output logic [NBITS-1:0] sw,
   output logic [NBITS-1:0] swb,
   output logic             busy,
   output logic [NBITS-1:0] data,
   output logic             valid
);

   generate
      if (!sar_params_ok(NBITS, SAMPLE_CYCLES)) begin : g_bad_params
         $error("sar_ctrl_param: illegal NBITS/SAMPLE_CYCLES combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

   sar_state_e       state;
   sar_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;

   logic             sh_clear;
   logic             sh_load;
   logic             sh_shift;
   logic [NBITS-1:0] trial;
   logic [NBITS-1:0] res;
   logic [NBITS-1:0] res_nxt;
   logic             last;

   sar_trial_shifter #(
      .NBITS (NBITS)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (sh_clear),
      .load    (sh_load),
      .shift   (sh_shift),
      .comp_in (comp_in),
      .trial   (trial),
      .res     (res),
      .res_nxt (res_nxt),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_SAMPLE;
         ST_SAMPLE: if (cnt == '0) state_nxt = ST_CONV;
         ST_CONV:   if (last) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = cont ? ST_SAMPLE : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sample   = (state == ST_SAMPLE);
      comp_en  = (state == ST_CONV);
      busy     = (state != ST_IDLE);
      sh_load  = (state == ST_SAMPLE) && (cnt == '0);
      sh_shift = (state == ST_CONV);
      // Clearing in DONE keeps res at zero through IDLE and the next SAMPLE.
      sh_clear = (state == ST_DONE);
   end

   // Reloaded on every entry into SAMPLE, from IDLE or from DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if ((state_nxt == ST_SAMPLE) && (state != ST_SAMPLE)) begin
         cnt <= CNT_LOAD;
      end else if ((state == ST_SAMPLE) && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Registered on the final CONV edge so data and valid both appear in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= (state == ST_CONV) && last;
         if ((state == ST_CONV) && last) begin
            data <= res_nxt;
         end
      end
   end

   assign sw  = {NBITS{sample}} | trial | res;
   assign swb = ~sw;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Bench for sar_ctrl_param: three instances (6/2, 2/1, 12/15) driven by an
// ideal comparator (comp_in = sw <= vin) and checked every cycle against a
// timeline model of one conversion.
module tb_sar_ctrl_param;

   localparam int NA = 6,  SA = 2;
   localparam int NB = 2,  SB = 1;
   localparam int NC = 12, SC = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit armed  = 1'b0;

   // instance A
   logic          rst_n_a = 1'b0, start_a = 1'b0, cont_a = 1'b0;
   logic          comp_in_a, comp_en_a, sample_a, busy_a, valid_a;
   logic [NA-1:0] sw_a, swb_a, data_a, vin_a = '0;
   // instances B and C
   logic          rst_n_bc = 1'b0;
   logic          start_b = 1'b0, cont_b = 1'b0;
   logic          comp_in_b, comp_en_b, sample_b, busy_b, valid_b;
   logic [NB-1:0] sw_b, swb_b, data_b, vin_b = '0;
   logic          start_c = 1'b0, cont_c = 1'b0;
   logic          comp_in_c, comp_en_c, sample_c, busy_c, valid_c;
   logic [NC-1:0] sw_c, swb_c, data_c, vin_c = '0;

   assign comp_in_a = (sw_a <= vin_a);
   assign comp_in_b = (sw_b <= vin_b);
   assign comp_in_c = (sw_c <= vin_c);

   sar_ctrl_param #(.NBITS(NA), .SAMPLE_CYCLES(SA)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .cont(cont_a), .comp_in(comp_in_a),
      .comp_en(comp_en_a), .sample(sample_a), .sw(sw_a), .swb(swb_a), .busy(busy_a),
      .data(data_a), .valid(valid_a));
   sar_ctrl_param #(.NBITS(NB), .SAMPLE_CYCLES(SB)) u_dut_b (
      .clk(clk), .rst_n(rst_n_bc), .start(start_b), .cont(cont_b), .comp_in(comp_in_b),
      .comp_en(comp_en_b), .sample(sample_b), .sw(sw_b), .swb(swb_b), .busy(busy_b),
      .data(data_b), .valid(valid_b));
   sar_ctrl_param #(.NBITS(NC), .SAMPLE_CYCLES(SC)) u_dut_c (
      .clk(clk), .rst_n(rst_n_bc), .start(start_c), .cont(cont_c), .comp_in(comp_in_c),
      .comp_en(comp_en_c), .sample(sample_c), .sw(sw_c), .swb(swb_c), .busy(busy_c),
      .data(data_c), .valid(valid_c));

   // ---------------- reference model ----------------
   // ph = 0 idle, otherwise the 1-based cycle within a conversion:
   // 1..S sample, S+1..S+N bit trials MSB first, S+N+1 result cycle.
   int ph_a = 0, ph_b = 0, ph_c = 0;
   int dexp_a = 0, dexp_b = 0, dexp_c = 0;
   int acc_a = 0, acc_b = 0, acc_c = 0;

   typedef struct {
      bit sample;
      bit comp_en;
      bit busy;
      bit valid;
      int sw;
   } exp_t;

   task automatic step(input int n, input int s, input logic rst, input logic st,
                       input logic ct, input int vin, inout int ph, inout int dexp);
      if (!rst) begin
         ph   = 0;
         dexp = 0;
      end else if (ph == 0) begin
         if (st) ph = 1;
      end else if (ph == s + n) begin
         dexp = vin;
         ph   = ph + 1;
      end else if (ph == s + n + 1) begin
         ph = ct ? 1 : 0;
      end else begin
         ph = ph + 1;
      end
   endtask

   always @(posedge clk) begin
      int p;
      cyc = cyc + 1;
      p = ph_a;
      step(NA, SA, rst_n_a, start_a, cont_a, int'(vin_a), ph_a, dexp_a);
      if (p == 0 && ph_a == 1) acc_a = cyc;
      p = ph_b;
      step(NB, SB, rst_n_bc, start_b, cont_b, int'(vin_b), ph_b, dexp_b);
      if (p == 0 && ph_b == 1) acc_b = cyc;
      p = ph_c;
      step(NC, SC, rst_n_bc, start_c, cont_c, int'(vin_c), ph_c, dexp_c);
      if (p == 0 && ph_c == 1) acc_c = cyc;
   end

   function automatic exp_t expect_outs(input int n, input int s, input int ph,
                                        input int vin, input int dexp);
      exp_t e;
      int   k;
      int   mask;
      mask      = (1 << n) - 1;
      e.sample  = 1'b0;
      e.comp_en = 1'b0;
      e.busy    = 1'b0;
      e.valid   = 1'b0;
      e.sw      = 0;
      if (ph >= 1 && ph <= s) begin
         e.sample = 1'b1;
         e.busy   = 1'b1;
         e.sw     = mask;
      end else if (ph > s && ph <= s + n) begin
         k         = n - 1 - (ph - s - 1);
         e.comp_en = 1'b1;
         e.busy    = 1'b1;
         // bits above the trial bit already equal the input code
         e.sw      = (vin & mask & ~((1 << (k + 1)) - 1)) | (1 << k);
      end else if (ph == s + n + 1) begin
         e.valid = 1'b1;
         e.busy  = 1'b1;
         e.sw    = dexp;
      end
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic chk(input string nm, input int n, input int s, input int ph,
                      input int vin, input int dexp, input logic [11:0] sw,
                      input logic [11:0] swb, input logic [11:0] data, input logic sample,
                      input logic comp_en, input logic busy, input logic valid);
      exp_t e;
      int   mask;
      e    = expect_outs(n, s, ph, vin, dexp);
      mask = (1 << n) - 1;
      cmp({nm, ".sw"},      32'(sw),      32'(e.sw));
      cmp({nm, ".swb"},     32'(swb),     32'(~e.sw & mask));
      cmp({nm, ".data"},    32'(data),    32'(dexp));
      cmp({nm, ".sample"},  32'(sample),  32'(e.sample));
      cmp({nm, ".comp_en"}, 32'(comp_en), 32'(e.comp_en));
      cmp({nm, ".busy"},    32'(busy),    32'(e.busy));
      cmp({nm, ".valid"},   32'(valid),   32'(e.valid));
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("a", NA, SA, ph_a, int'(vin_a), dexp_a, 12'(sw_a), 12'(swb_a), 12'(data_a),
             sample_a, comp_en_a, busy_a, valid_a);
         chk("b", NB, SB, ph_b, int'(vin_b), dexp_b, 12'(sw_b), 12'(swb_b), 12'(data_b),
             sample_b, comp_en_b, busy_b, valid_b);
         chk("c", NC, SC, ph_c, int'(vin_c), dexp_c, sw_c, swb_c, data_c,
             sample_c, comp_en_c, busy_c, valid_c);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [NA-1:0] sw_seq [6] = '{6'b100000, 6'b110000, 6'b101000,
                                 6'b101100, 6'b101010, 6'b101011};
   logic [NA-1:0] q_sw [$];

   task automatic tick();
      @(negedge clk);
   endtask

   // One start pulse on A; returns at the negedge of the valid cycle.
   task automatic run_conv_a(input logic [NA-1:0] v, output int lat,
                             output int ncomp, output int nsamp);
      vin_a = v;
      q_sw.delete();
      ncomp = 0;
      nsamp = 0;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid_a) break;
         if (sample_a) begin
            nsamp++;
            cmp("a.sw_in_sample", 32'(sw_a), 32'h3F);
         end
         if (comp_en_a) begin
            ncomp++;
            q_sw.push_back(sw_a);
         end
         tick();
      end
      cmp("a.valid_seen", 32'(valid_a), 1);
      lat = cyc + 1 - acc_a;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      cmp("a.reset_sw",   32'(sw_a),   32'h00);
      cmp("a.reset_swb",  32'(swb_a),  32'h3F);
      cmp("a.reset_busy", 32'(busy_a), 0);
      rst_n_a  = 1'b1;
      rst_n_bc = 1'b1;
      armed    = 1'b1;
      fork
         begin : thr_a
            int lat, nc, ns, nval, drop_at;
            int vc [4];
            logic [NA-1:0] v;
            // known code 0x2B
            run_conv_a(6'h2B, lat, nc, ns);
            cmp("a.s1_latency", 32'(lat), 9);
            cmp("a.s1_data", 32'(data_a), 32'h2B);
            cmp("a.s1_ncomp", 32'(nc), 6);
            cmp("a.s1_nsamp", 32'(ns), 2);
            for (int i = 0; i < 6; i++) begin
               if (i < q_sw.size()) cmp("a.s1_sw_seq", 32'(q_sw[i]), 32'(sw_seq[i]));
            end
            tick();
            // extreme codes
            run_conv_a(6'h00, lat, nc, ns);
            cmp("a.s2_data_zero", 32'(data_a), 32'h00);
            cmp("a.s2_ncomp_zero", 32'(nc), 6);
            tick();
            run_conv_a(6'h3F, lat, nc, ns);
            cmp("a.s2_data_full", 32'(data_a), 32'h3F);
            cmp("a.s2_ncomp_full", 32'(nc), 6);
            tick();
            // continuous: four conversions, cont dropped in the fourth DONE
            cont_a = 1'b1;
            vin_a  = 6'($urandom);
            tick();
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            for (int n = 0; n < 4; n++) begin
               for (int i = 0; i < 30; i++) begin
                  if (valid_a) break;
                  tick();
               end
               cmp("a.s3_valid", 32'(valid_a), 1);
               vc[n] = cyc;
               if (n == 3) cont_a = 1'b0;
               vin_a = 6'($urandom);
               tick();
            end
            for (int n = 1; n < 4; n++) cmp("a.s3_spacing", 32'(vc[n] - vc[n-1]), 9);
            tick();
            cmp("a.s3_idle", 32'(busy_a), 0);
            // cont dropped during the third conversion
            cont_a = 1'b1;
            vin_a  = 6'($urandom);
            tick();
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            nval    = 0;
            drop_at = -1;
            for (int i = 0; i < 80; i++) begin
               if (valid_a) begin
                  nval++;
                  if (nval == 2) drop_at = i + 4;
               end
               if (i == drop_at) cont_a = 1'b0;
               tick();
            end
            cmp("a.s3_drop_nvalid", 32'(nval), 3);
            cmp("a.s3_drop_idle", 32'(busy_a), 0);
            // start hammered during CONV
            vin_a = 6'($urandom);
            v     = vin_a;
            tick();
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            nval    = 0;
            for (int i = 0; i < 40; i++) begin
               start_a = comp_en_a && (i % 2 == 0);
               if (valid_a) begin
                  nval++;
                  cmp("a.s4_data", 32'(data_a), 32'(v));
               end
               tick();
            end
            start_a = 1'b0;
            cmp("a.s4_nvalid", 32'(nval), 1);
            cmp("a.s4_idle", 32'(busy_a), 0);
            // reset at the third CONV cycle
            vin_a = 6'h15;
            tick();
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            nc      = 0;
            for (int i = 0; i < 20; i++) begin
               if (comp_en_a) nc++;
               if (nc == 3) break;
               tick();
            end
            cmp("a.s5_reached_conv3", 32'(nc), 3);
            rst_n_a = 1'b0;
            tick();
            rst_n_a = 1'b1;
            cmp("a.s5_sw",      32'(sw_a),      32'h00);
            cmp("a.s5_swb",     32'(swb_a),     32'h3F);
            cmp("a.s5_data",    32'(data_a),    32'h00);
            cmp("a.s5_valid",   32'(valid_a),   0);
            cmp("a.s5_busy",    32'(busy_a),    0);
            cmp("a.s5_sample",  32'(sample_a),  0);
            cmp("a.s5_comp_en", 32'(comp_en_a), 0);
            nval = 0;
            for (int i = 0; i < 20; i++) begin
               if (valid_a) nval++;
               tick();
            end
            cmp("a.s5_no_valid", 32'(nval), 0);
            run_conv_a(6'h26, lat, nc, ns);
            cmp("a.s5_after_data", 32'(data_a), 32'h26);
            cmp("a.s5_after_latency", 32'(lat), 9);
            tick();
            // random mix of single and back-to-back conversions
            for (int n = 0; n < 40; n++) begin
               v      = 6'($urandom);
               vin_a  = v;
               cont_a = 1'($urandom);
               tick();
               start_a = 1'b1;
               tick();
               start_a = 1'b0;
               for (int i = 0; i < 30; i++) begin
                  if (valid_a) break;
                  start_a = comp_en_a & 1'($urandom);
                  tick();
               end
               start_a = 1'b0;
               cmp("a.r_valid", 32'(valid_a), 1);
               cmp("a.r_data", 32'(data_a), 32'(v));
               if (cont_a) begin
                  v     = 6'($urandom);
                  vin_a = v;
                  tick();
                  cont_a = 1'b0;
                  for (int i = 0; i < 30; i++) begin
                     if (valid_a) break;
                     tick();
                  end
                  cmp("a.r_cont_valid", 32'(valid_a), 1);
                  cmp("a.r_cont_data", 32'(data_a), 32'(v));
               end
               tick();
               tick();
               cmp("a.r_idle", 32'(busy_a), 0);
            end
         end
         begin : thr_b
            logic [NB-1:0] v;
            for (int n = 0; n < 200; n++) begin
               v     = 2'($urandom);
               vin_b = v;
               tick();
               start_b = 1'b1;
               tick();
               start_b = 1'b0;
               for (int i = 0; i < 20; i++) begin
                  if (valid_b) break;
                  tick();
               end
               cmp("b.valid", 32'(valid_b), 1);
               cmp("b.latency", 32'(cyc + 1 - acc_b), 32'(SB + NB + 1));
               cmp("b.data", 32'(data_b), 32'(v));
               tick();
            end
         end
         begin : thr_c
            logic [NC-1:0] v;
            for (int n = 0; n < 200; n++) begin
               v     = 12'($urandom);
               vin_c = v;
               tick();
               start_c = 1'b1;
               tick();
               start_c = 1'b0;
               for (int i = 0; i < 40; i++) begin
                  if (valid_c) break;
                  tick();
               end
               cmp("c.valid", 32'(valid_c), 1);
               cmp("c.latency", 32'(cyc + 1 - acc_c), 32'(SC + NC + 1));
               cmp("c.data", 32'(data_c), 32'(v));
               tick();
            end
         end
      join
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
